// File: rtl/rnd_arbiter.sv
// rnd_arbiter: round-robin sharing of an LFSR word among requesters, each
// receiving a number in [0, limit) by mask-and-reject sampling.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   rnd_num_i    free-running LFSR word (RND_W bits, advances every clock)
//   req_i        level request per requester, held until its grant
//   limit_i      packed exclusive bounds, requester i at [i*OUT_W +: OUT_W], 0 = 2^OUT_W
//   gnt_o        one-hot single-cycle grant
//   rnd_o        result, valid while rnd_valid_o is high
//   rnd_valid_o  high together with the gnt_o pulse
//   busy_o       high while a transaction is in SAMPLE or RESP
module rnd_arbiter #(
  parameter int N_REQ     = 3,
  parameter int RND_W     = 16,
  parameter int OUT_W     = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [RND_W-1:0]       rnd_num_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*OUT_W-1:0] limit_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [OUT_W-1:0]       rnd_o,
  output logic                   rnd_valid_o,
  output logic                   busy_o
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(MAX_TRIES + 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, RESP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, idx, off, sel;
  logic [PW:0] sum;
  logic [2*N_REQ-1:0] rot;
  logic found;
  logic [OUT_W-1:0] lim, mask, lim_sel, mask_sel, cand, res, res_n;
  logic [TW-1:0] tries;
  logic accept, last;
  logic unused_bits;
  assign unused_bits = ^rnd_num_i;
  // Rotate the doubled request vector so the lowest set bit is the first
  // requester at or after ptr.
  always_comb begin
    rot = {req_i, req_i} >> ptr;
    found = |req_i;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = PW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    sel = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
  end
  // Smear lim-1 rightwards: mask covers every bit up to its MSB.
  // lim=0 wraps to all-ones, lim=1 gives 0.
  always_comb begin
    lim_sel = limit_i[sel*OUT_W +: OUT_W];
    mask_sel = lim_sel - OUT_W'(1);
    for (int i = 0; i < OUT_W; i++)
      mask_sel = mask_sel | (mask_sel >> 1);
  end
  // mask < 2*lim, so the fallback cand-lim is always below lim.
  always_comb begin
    cand = rnd_num_i[OUT_W-1:0] & mask;
    accept = (lim == '0) || (cand < lim);
    last = tries == TW'(MAX_TRIES - 1);
    res_n = accept ? cand : cand - lim;
    state_n = (state == IDLE)   ? (found ? SAMPLE : IDLE) :
              (state == SAMPLE) ? ((accept || last) ? RESP : SAMPLE) : IDLE;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ptr <= '0;
      idx <= '0;
      lim <= '0;
      mask <= '0;
      tries <= '0;
      res <= '0;
      gnt_o <= '0;
      rnd_valid_o <= 1'b0;
      rnd_o <= '0;
    end else begin
      gnt_o <= '0;
      rnd_valid_o <= 1'b0;
      if (state == IDLE && found) begin
        idx <= sel;
        lim <= lim_sel;
        mask <= mask_sel;
        tries <= '0;
      end
      if (state == SAMPLE) begin
        tries <= tries + TW'(1);
        res <= res_n;
      end
      if (state == RESP) begin
        ptr <= (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
        if (req_i[idx]) begin
          gnt_o <= N_REQ'(1) << idx;
          rnd_valid_o <= 1'b1;
          rnd_o <= res;
        end
      end
    end
endmodule

// File: tb/tb_rnd_arbiter.sv
// tb_rnd_arbiter: randomized self-checking bench for rnd_arbiter against a behavioural model.
module tb_rnd_arbiter;
  localparam int N = 3, RW = 16, OW = 8, MT = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [RW-1:0] rnd_num_i = '0;
  logic [N-1:0] req_i = '0;
  logic [N*OW-1:0] limit_i = '0;
  logic [N-1:0] gnt_o;
  logic [OW-1:0] rnd_o;
  logic rnd_valid_o, busy_o;
  int n_chk = 0, n_fail = 0;
  logic [15:0] fw[$];

  rnd_arbiter #(.N_REQ(N), .RND_W(RW), .OUT_W(OW), .MAX_TRIES(MT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rnd_num_i(rnd_num_i), .req_i(req_i),
    .limit_i(limit_i), .gnt_o(gnt_o), .rnd_o(rnd_o), .rnd_valid_o(rnd_valid_o),
    .busy_o(busy_o));

  always #5 clk = ~clk;

  // One transaction for requester r; returns what was observed plus the
  // model's expected result and latency from the words actually supplied.
  task automatic txn(input int r, input logic [7:0] lim, output logic [2:0] g,
                     output logic [7:0] got, output logic [7:0] exp, output int lat,
                     output int exp_lat);
    logic [15:0] w[$];
    int c, m, cand, e, used;
    bit seen;
    @(negedge clk);
    limit_i[r*OW +: OW] = lim;
    req_i[r] = 1'b1;
    rnd_num_i = 16'($urandom);
    c = 0; seen = 0; g = '0; got = '0;
    while (!seen && c < 30) begin
      @(negedge clk);
      c++;
      if (gnt_o != 0 || rnd_valid_o) begin
        seen = 1; g = gnt_o; got = rnd_o; req_i[r] = 1'b0;
      end else begin
        if (fw.size() > 0) w.push_back(fw.pop_front());
        else w.push_back(16'($urandom));
        rnd_num_i = w[w.size()-1];
      end
    end
    req_i[r] = 1'b0;
    lat = seen ? c - 1 : -1;
    m = 0;
    if (lim == 0) m = 255;
    else while (m < int'(lim) - 1) m = m * 2 + 1;
    e = -1; used = 0;
    for (int t = 0; t < MT && t < w.size(); t++) begin
      cand = int'(w[t][7:0]) & m;
      if (lim == 0 || cand < int'(lim)) begin e = cand; used = t + 1; break; end
      if (t == MT - 1) begin e = cand - int'(lim); used = t + 1; end
    end
    exp = 8'(e);
    exp_lat = used + 1;
  endtask

  // Waits for the next grant, dropping the granted request; flags a valid without grant.
  task automatic wait_gnt(output logic [2:0] g, output bit stray);
    int c;
    g = '0; stray = 0; c = 0;
    while (g == 0 && c < 16) begin
      @(negedge clk);
      c++;
      rnd_num_i = 16'($urandom);
      if (rnd_valid_o && gnt_o == 0) stray = 1;
      if (gnt_o != 0) begin g = gnt_o; req_i = req_i & ~gnt_o; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_chk++; if ({gnt_o, rnd_valid_o, busy_o, rnd_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got gnt=%b valid=%b busy=%b rnd=%0d, want all 0", gnt_o, rnd_valid_o, busy_o, rnd_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    int order[$];
    int rr[3];
    int c, last;
    limit_i = '0;
    rr = '{-1, -1, -1};
    @(negedge clk);
    req_i = 3'b111;
    c = 0;
    while (order.size() < 6 && c < 60) begin
      @(negedge clk);
      c++;
      rnd_num_i = 16'($urandom);
      for (int i = 0; i < 3; i++) if (rr[i] == c) req_i[i] = 1'b1;
      if (gnt_o != 0) begin
        n_chk++; if (!$onehot(gnt_o)) begin
          n_fail++; $display("FAIL rr_onehot: got gnt=%b, want one-hot", gnt_o);
        end
        for (int i = 0; i < 3; i++)
          if (gnt_o[i]) begin order.push_back(i); req_i[i] = 1'b0; rr[i] = c + 1; end
      end
    end
    req_i = '0;
    n_chk++; if (order.size() != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d grants, want 6", order.size());
    end
    last = -1;
    foreach (order[k]) begin
      n_chk++; if (order[k] != (last + 1) % 3) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d, want %0d", k, order[k], (last + 1) % 3);
      end
      last = order[k];
    end
  endtask

  task automatic test_single;
    logic [2:0] g; logic [7:0] got, exp; int lat, el;
    fw = '{16'h1235};
    txn(0, 8'd6, g, got, exp, lat, el);
    n_chk++; if (g !== 3'b001 || got !== 8'd5 || lat != 2) begin
      n_fail++; $display("FAIL single: got gnt=%b rnd=%0d lat=%0d, want gnt=001 rnd=5 lat=2", g, got, lat);
    end
  endtask

  task automatic test_fallback;
    logic [2:0] g; logic [7:0] got, exp; int lat, el;
    fw = '{16'h3307, 16'h1206, 16'hAA07, 16'h0106, 16'hFF07, 16'h0006, 16'h5507, 16'h7706};
    txn(2, 8'd5, g, got, exp, lat, el);
    n_chk++; if (g !== 3'b100 || got !== 8'd1 || lat != MT + 1) begin
      n_fail++; $display("FAIL fallback: got gnt=%b rnd=%0d lat=%0d, want gnt=100 rnd=1 lat=%0d", g, got, lat, MT + 1);
    end
  endtask

  task automatic test_limits;
    logic [2:0] g; logic [7:0] got, exp; int lat, el, r;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 2);
      txn(r, 8'd1, g, got, exp, lat, el);
      n_chk++; if (got !== 8'd0 || lat != 2 || g !== 3'(1 << r)) begin
        n_fail++; $display("FAIL limit1[%0d]: got gnt=%b rnd=%0d lat=%0d, want gnt=%b rnd=0 lat=2", k, g, got, lat, 3'(1 << r));
      end
    end
    fw = '{16'h00FF};
    txn(1, 8'd0, g, got, exp, lat, el);
    n_chk++; if (g !== 3'b010 || got !== 8'd255 || lat != 2) begin
      n_fail++; $display("FAIL limit0: got gnt=%b rnd=%0d lat=%0d, want gnt=010 rnd=255 lat=2", g, got, lat);
    end
  endtask

  task automatic test_random;
    logic [2:0] g; logic [7:0] got, exp, lim; int lat, el, r;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 2);
      lim = $urandom_range(0, 1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      txn(r, lim, g, got, exp, lat, el);
      n_chk++; if (g !== 3'(1 << r) || got !== exp || lat != el) begin
        n_fail++; $display("FAIL random[%0d] lim=%0d: got gnt=%b rnd=%0d lat=%0d, want gnt=%b rnd=%0d lat=%0d",
                           k, lim, g, got, lat, 3'(1 << r), exp, el);
      end
    end
  endtask

  task automatic test_withdraw;
    logic [2:0] g; logic [7:0] got, exp; int lat, el; bit stray;
    txn(0, 8'd0, g, got, exp, lat, el);
    n_chk++; if (g !== 3'b001) begin
      n_fail++; $display("FAIL wd_setup: got gnt=%b, want 001", g);
    end
    @(negedge clk);
    limit_i = '0;
    req_i = 3'b011;
    @(negedge clk);
    req_i[1] = 1'b0;
    wait_gnt(g, stray);
    n_chk++; if (g !== 3'b001 || stray) begin
      n_fail++; $display("FAIL wd_next: got gnt=%b stray_valid=%0d, want gnt=001 stray_valid=0", g, stray);
    end
    @(negedge clk);
    req_i = 3'b010;
    @(negedge clk);
    req_i = 3'b101;
    wait_gnt(g, stray);
    n_chk++; if (g !== 3'b100 || stray) begin
      n_fail++; $display("FAIL wd_ptr: got gnt=%b stray_valid=%0d, want gnt=100 stray_valid=0", g, stray);
    end
    wait_gnt(g, stray);
    n_chk++; if (g !== 3'b001) begin
      n_fail++; $display("FAIL wd_rest: got gnt=%b, want 001", g);
    end
    req_i = '0;
  endtask

  task automatic test_reset_mid;
    logic [2:0] g; logic [7:0] got, exp; int lat, el; bit stray;
    txn(1, 8'd0, g, got, exp, lat, el);
    @(negedge clk);
    limit_i[2*OW +: OW] = 8'd5;
    req_i[2] = 1'b1;
    rnd_num_i = 16'h0007;
    @(negedge clk);
    rnd_num_i = 16'h0007;
    n_chk++; if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL rm_busy: got busy=%b, want 1", busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy_o, gnt_o, rnd_valid_o} !== '0) begin
      n_fail++; $display("FAIL rm_async: got busy=%b gnt=%b valid=%b, want 0", busy_o, gnt_o, rnd_valid_o);
    end
    req_i = '0;
    limit_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 3'b110;
    wait_gnt(g, stray);
    n_chk++; if (g !== 3'b010 || stray) begin
      n_fail++; $display("FAIL rm_ptr0: got gnt=%b stray_valid=%0d, want gnt=010 stray_valid=0", g, stray);
    end
    wait_gnt(g, stray);
    req_i = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_fallback();
    test_limits();
    test_random();
    test_withdraw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
